// File: rtl/uart_tx_arbiter.sv
// Shares one UART sender among NUM_REQ byte requesters: round-robin grant, one-cycle Ack, send watchdog.
// Define UART_TX_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 highest) instead of round-robin.
module uart_tx_arbiter #(
  parameter int                   NUM_REQ   = 2,
  parameter int                   TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000
) (
  input  logic                 Clk_100M,
  input  logic                 Reset,
  input  logic [NUM_REQ-1:0]   Req,
  input  logic [8*NUM_REQ-1:0] Req_Data,
  output logic [NUM_REQ-1:0]   Ack,
  output logic [NUM_REQ-1:0]   Grant,
  output logic [7:0]           Tx_Data,
  output logic                 Tx_Send,
  input  logic                 Tx_Busy,
  output logic                 Timeout_Err
);

  localparam int                   IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]          ack_q, ack_d;
  logic [7:0]                  data_q, data_d;
  logic                        send_q, send_d;
  logic                        terr_q, terr_d;
  logic [TIMEOUT_W-1:0]        timer_q, timer_d;
  logic [IW-1:0]               win;
  logic [NUM_REQ-1:0][7:0]     req_byte;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_byte[g] = Req_Data[8*g +: 8];
  end

`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
  always_comb begin
    win = '0;
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (Req[i]) win = IW'(i);
  end
`else
  logic [IW-1:0] last_q, last_d;

  // Search from last_grant+1 upward with wrap; walking k downward leaves the nearest hit.
  always_comb begin
    win = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (Req[(int'(last_q) + k) % NUM_REQ]) win = IW'((int'(last_q) + k) % NUM_REQ);
  end

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && |Req && !Tx_Busy) last_d = win;
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset) last_q <= IW'(NUM_REQ-1);
    else        last_q <= last_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    send_d  = send_q;
    terr_d  = 1'b0;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (|Req && !Tx_Busy) begin
          data_d  = req_byte[win];
          send_d  = 1'b1;
          grant_d = NUM_REQ'(1) << win;
          timer_d = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        if (Tx_Busy) begin
          send_d  = 1'b0;
          ack_d   = grant_q;
          state_d = S_DRAIN;
        end else if (timer_q == TMAX) begin
          send_d  = 1'b0;
          grant_d = '0;
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Frame length of the sender bounds this wait; no watchdog here.
        if (!Tx_Busy) begin
          grant_d = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_100M) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
      terr_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      send_q  <= send_d;
      terr_q  <= terr_d;
      timer_q <= timer_d;
    end
  end

  assign Ack         = ack_q;
  assign Grant       = grant_q;
  assign Tx_Data     = data_q;
  assign Tx_Send     = send_q;
  assign Timeout_Err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_uart_tx_arbiter;
  localparam int          N  = 2;
  localparam logic [15:0] TO = 16'd8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   ack, grant;
  logic [7:0]     tx_data;
  logic           tx_send, terr;
  logic           tx_busy = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_W(16), .TIMEOUT(TO)) dut (
    .Clk_100M(clk), .Reset(rst_n), .Req(req), .Req_Data(req_data),
    .Ack(ack), .Grant(grant), .Tx_Data(tx_data), .Tx_Send(tx_send),
    .Tx_Busy(tx_busy), .Timeout_Err(terr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sender model: raises Busy blat cycles after seeing Tx_Send, holds it blen cycles.
  bit force_busy = 0, mute = 0;
  int blat = 1, blen = 20, scnt = 0, sdly = 0;
  always @(negedge clk) begin
    if (force_busy) begin
      tx_busy = 1'b1; scnt = 0; sdly = 0;
    end else if (scnt > 0) begin
      scnt--; tx_busy = (scnt != 0);
    end else begin
      tx_busy = 1'b0;
      if (tx_send === 1'b1 && !mute) begin
        sdly++;
        if (sdly >= blat) begin tx_busy = 1'b1; scnt = blen; sdly = 0; end
      end else sdly = 0;
    end
  end

  // Reference model: who should own the sender, what is in flight, how long it waited.
  function automatic int pick(input logic [N-1:0] r, input int last);
    int res;
    res = -1;
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
    for (int i = N-1; i >= 0; i--) if (r[i]) res = i;
`else
    for (int k = N; k >= 1; k--) if (r[(last+k)%N]) res = (last+k)%N;
`endif
    return res;
  endfunction

  int         m_phase, m_last, m_wait, w;
  bit         m_ok = 0;
  logic [N-1:0] e_grant, e_ack;
  logic [7:0] e_data;
  logic       e_send, e_terr;

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      m_phase = 0; m_last = N-1; m_wait = 0; m_ok = 1;
      e_grant = '0; e_ack = '0; e_data = '0; e_send = 0; e_terr = 0;
    end else if (m_ok) begin
      e_ack = '0; e_terr = 0;
      if (m_phase == 0) begin
        if (req != 0 && !tx_busy) begin
          w = pick(req, m_last);
          e_data = req_data[8*w +: 8];
          e_send = 1; e_grant = '0; e_grant[w] = 1'b1;
          m_last = w; m_wait = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (tx_busy) begin
          e_send = 0; e_ack = e_grant; m_phase = 2;
        end else begin
          m_wait++;
          if (m_wait == int'(TO)) begin
            e_send = 0; e_grant = '0; e_terr = 1; m_phase = 0;
          end
        end
      end else if (!tx_busy) begin
        e_grant = '0; m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("grant", grant, e_grant);
      chk("ack", ack, e_ack);
      chk("tx_send", tx_send, e_send);
      chk("tx_data", tx_data, e_data);
      chk("timeout_err", terr, e_terr);
      chk("ack_terr_excl", 32'((ack != 0) && terr), 0);
      chk("grant_onehot0", 32'($onehot0(grant)), 1);
    end
  end

  task automatic wait_send(input string nm);
    int n = 0;
    while (tx_send !== 1'b1 && n < 200) begin tick(); n++; end
    chk(nm, tx_send, 1);
  endtask

  task automatic wait_nosend(input string nm);
    int n = 0;
    while (tx_send !== 1'b0 && n < 200) begin tick(); n++; end
    chk(nm, tx_send, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((grant != 0 || tx_busy) && n < 200) begin tick(); n++; end
    chk(nm, 32'(grant == 0 && !tx_busy), 1);
  endtask

  logic [N-1:0] exp_g [4];
  logic [7:0]   exp_d [4];

  initial begin
    int cnt;
    rst_n = 0; req = '0; req_data = '0;
    repeat (3) tick();
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_terr", terr, 0);

    // Single request, Busy one cycle after Tx_Send for 20 cycles.
    blat = 1; blen = 20;
    rst_n = 1; req = 2'b01; req_data = 16'h0041;
    tick();
    chk("t1_send", tx_send, 1);
    chk("t1_data", tx_data, 8'h41);
    chk("t1_grant", grant, 2'b01);
    tick();
    chk("t1_ack", ack, 2'b01);
    chk("t1_send_low", tx_send, 0);
    req = 2'b00;
    tick();
    chk("t1_ack_once", ack, 0);
    chk("t1_grant_held", grant, 2'b01);
    wait_idle("t1_idle");

    // Both requesting continuously.
    rst_n = 0; tick(); rst_n = 1;
    req = 2'b11; req_data = 16'h4241; blen = 4;
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01}; exp_d = '{8'h41, 8'h41, 8'h41, 8'h41};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10}; exp_d = '{8'h41, 8'h42, 8'h41, 8'h42};
`endif
    for (int i = 0; i < 4; i++) begin
      blat = $urandom_range(1, 3);
      wait_send("t2_send");
      chk("t2_grant_seq", grant, exp_g[i]);
      chk("t2_data_seq", tx_data, exp_d[i]);
      wait_nosend("t2_send_drop");
    end
    req = 2'b00;
    wait_idle("t2_idle");

    // Busy already high: no grant until it falls.
    force_busy = 1; blat = 1; blen = 4;
    tick();
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_no_send", tx_send, 0);
      chk("t3_no_grant", grant, 0);
    end
    force_busy = 0;
    tick();
    chk("t3_grant", grant, 2'b10);
    chk("t3_send", tx_send, 1);
    chk("t3_data", tx_data, 8'h42);
    req = 2'b00;
    wait_idle("t3_idle");

    // Watchdog: sender never answers.
    mute = 1; req = 2'b01;
    tick();
    chk("t4_send", tx_send, 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_send) cnt++;
      else break;
    end
    chk("t4_send_cycles", cnt, 8);
    chk("t4_terr", terr, 1);
    chk("t4_no_ack", ack, 0);
    chk("t4_grant_cleared", grant, 0);
    req = 2'b11; mute = 0;
    tick();
    chk("t4_terr_once", terr, 0);
`ifdef UART_TX_ARB_FIXED_PRIORITY_EN
    chk("t4_next_grant", grant, 2'b01);
`else
    chk("t4_next_grant", grant, 2'b10);
`endif
    req = 2'b00;
    wait_idle("t4_idle");

    // Reset in the middle of a transaction.
    blat = 1; blen = 20; req = 2'b01;
    tick();
    chk("t5_send", tx_send, 1);
    repeat (3) tick();
    rst_n = 0;
    tick();
    chk("t5_rst_ack", ack, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_send", tx_send, 0);
    chk("t5_rst_data", tx_data, 0);
    chk("t5_rst_terr", terr, 0);
    rst_n = 1; req = 2'b11;
    wait_send("t5_send_after");
    chk("t5_first_grant", grant, 2'b01);
    req = 2'b00;
    wait_idle("t5_idle");

    // Data and Req changes after grant are ignored.
    blat = 3; blen = 5; req = 2'b01; req_data = 16'h0041;
    tick();
    chk("t6_send", tx_send, 1);
    req_data = 16'h0055; req = 2'b00;
    tick();
    chk("t6_data_latched", tx_data, 8'h41);
    cnt = 0;
    while (ack == 0 && cnt < 20) begin tick(); cnt++; end
    chk("t6_ack", ack, 2'b01);
    chk("t6_data_at_ack", tx_data, 8'h41);
    tick();
    chk("t6_ack_once", ack, 0);
    wait_idle("t6_idle");

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      req_data = 16'($urandom);
      blat = $urandom_range(1, 3);
      blen = $urandom_range(1, 6);
      if ($urandom_range(0, 59) == 0) mute = ~mute;
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    mute = 0; rst_n = 1; req = '0;
    wait_idle("rand_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART_Sender (8-bit Tx_Data / Tx_Send / Tx_Busy handshake) between NUM_REQ byte requesters, e.g. the receive-echo path and the buffer-playback path of the character display design.
- Round-robin grant, per-requester one-cycle Ack, and a watchdog so a stuck sender cannot lock the bus.
- Sits between the requesters and UART_Sender; the sender's Tx output is untouched.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_W, 16, width of the watchdog counter.
- TIMEOUT, 16'd50000, cycles to wait in SEND for Tx_Busy to rise before aborting.

Ports:
- Clk_100M  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- Req  input  NUM_REQ  level request per requester; Req_Data must be valid while high.
- Req_Data  input  8*NUM_REQ  byte per requester; requester i uses bits [8i+7:8i].
- Ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted by the sender.
- Grant  output  NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- Tx_Data  output  8  byte to UART_Sender.
- Tx_Send  output  1  send strobe to UART_Sender.
- Tx_Busy  input  1  busy flag from UART_Sender.
- Timeout_Err  output  1  one-cycle pulse when a transaction is aborted by the watchdog.

Behaviour:
- All outputs are registered.
- Reset (Reset==0 at a clock edge), including mid-transaction:
  - state=IDLE; Ack, Grant, Tx_Data, Tx_Send, Timeout_Err and the timer all 0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
- IDLE:
  - Arbitrates only if |Req and Tx_Busy==0. If Tx_Busy is already high, nothing is granted.
  - Winner is the first set Req bit searched from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Next edge: Tx_Data<=winner's Req_Data, Tx_Send<=1, Grant<=onehot(winner), last_grant<=winner, timer<=0, state<=SEND.
- SEND:
  - Tx_Send is held high and the timer increments each cycle.
  - If Tx_Busy==1 is sampled: Tx_Send<=0, Ack[winner]<=1 for exactly one cycle, state<=DRAIN.
  - Else, if timer==TIMEOUT-1: Tx_Send<=0, Grant<=0, Timeout_Err<=1 for one cycle, no Ack, state<=IDLE. last_grant stays at the failed winner, so the next search starts past it.
- DRAIN:
  - Waits for Tx_Busy==0, then Grant<=0 and state<=IDLE.
  - No watchdog in DRAIN; the sender's own frame length bounds it.
- Latency: Req seen in IDLE → Tx_Send high on the next cycle. Tx_Busy rise sampled → Ack on the next cycle.
- Back-to-back: Tx_Busy low sampled in DRAIN → IDLE → next Tx_Send two edges later. Successive frames are separated by at least 2 idle cycles of Tx_Send.
- Tx_Data is latched at grant. Changes on Req_Data or a dropped Req during SEND/DRAIN are ignored, and the transaction still completes with its Ack.
- A Req still high when the arbiter is next in IDLE counts as a new request. Requesters must drop Req or present the next byte on the cycle after Ack.
- Simultaneous requests: exactly one winner per transaction. No requester is granted twice while another holds Req continuously (starvation-free).
- Single requester: it is granted repeatedly.
- Ack and Timeout_Err are never high in the same cycle. Grant is at most one-hot.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins (requester 0 highest); last_grant is unused. All other behaviour is unchanged.
- Undefined (default): round-robin as above.

Test Plan:
- Reset released, Req=2'b01, Req_Data[7:0]=8'h41, sender model raises Tx_Busy 1 cycle after Tx_Send and holds it 20 cycles:
  - Tx_Send high next cycle with Tx_Data=8'h41.
  - Ack=2'b01 for one cycle after Busy is sampled.
  - Grant=2'b01 until Busy falls, then 0.
- Req=2'b11 held continuously, data 8'h41/8'h42: grants alternate 0,1,0,1 with Tx_Data 41,42,41,42. With UART_TX_ARB_FIXED_PRIORITY_EN defined: always requester 0, Tx_Data always 8'h41.
- Tx_Busy held high before Req=2'b10: no Tx_Send and Grant=0 until Busy falls; then requester 1 is granted the next cycle.
- TIMEOUT=16'd8, sender never raises Busy, Req=2'b01:
  - Tx_Send high exactly 8 cycles, then Timeout_Err pulses once, no Ack, back to IDLE.
  - With Req=2'b11 the next grant goes to requester 1.
- Reset driven low 3 cycles after Tx_Send rises: all outputs 0 on the next edge. After release with Req=2'b11, requester 0 is granted first.
- Req_Data changed from 8'h41 to 8'h55 and Req dropped during SEND: Tx_Data stays 8'h41 and Ack still pulses once.
